// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data cache access controller.
// Turns a decoded load/store into a held dREN/dWEN request, stalls the
// pipeline until dhit, and hands captured load data to the MEM/WB latch.
// Optional feature macro: LLSC_EN adds ll_in/sc_in and the LL/SC
// reservation (link_valid/link_addr).
module mem_access_ctrl (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        memRead_in,
    input  logic        memWrite_in,
    input  logic [31:0] aluResult_in,
    input  logic [31:0] storeData_in,
`ifdef LLSC_EN
    input  logic        ll_in,
    input  logic        sc_in,
`endif
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    output logic        mem_stall,
    output logic        mem_done,
    output logic [31:0] dmemload_out,
    output logic        misalign
);

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state, state_n;
    logic                req, aligned;
    logic                dren_n, dwen_n, done_n;
    logic [WORD_W-1:0]   daddr_n, dstore_n, dout_n;
`ifdef LLSC_EN
    logic                link_valid, link_valid_n;
    logic [WORD_W-1:0]   link_addr, link_addr_n;
    logic                op_ll, op_ll_n, op_sc, op_sc_n;
`endif

    // request decode; a simultaneous read and write is treated as a store
    assign req     = memRead_in | memWrite_in;
    assign aligned = (aluResult_in[1:0] == 2'b00);

    // combinational handshake toward the pipeline, held quiet during reset
    assign mem_stall = nRST & (((state == IDLE) & req & aligned) | (state == BUSY));
    assign misalign  = nRST & (state == IDLE) & req & ~aligned;

    // state and registered outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            dREN         <= 1'b0;
            dWEN         <= 1'b0;
            daddr        <= '0;
            dstore       <= '0;
            dmemload_out <= '0;
            mem_done     <= 1'b0;
`ifdef LLSC_EN
            link_valid   <= 1'b0;
            link_addr    <= '0;
            op_ll        <= 1'b0;
            op_sc        <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            dREN         <= dren_n;
            dWEN         <= dwen_n;
            daddr        <= daddr_n;
            dstore       <= dstore_n;
            dmemload_out <= dout_n;
            mem_done     <= done_n;
`ifdef LLSC_EN
            link_valid   <= link_valid_n;
            link_addr    <= link_addr_n;
            op_ll        <= op_ll_n;
            op_sc        <= op_sc_n;
`endif
        end
    end

    // next state and next register values
    always_comb begin
        state_n  = state;
        dren_n   = dREN;
        dwen_n   = dWEN;
        daddr_n  = daddr;
        dstore_n = dstore;
        dout_n   = dmemload_out;
        done_n   = 1'b0;
`ifdef LLSC_EN
        link_valid_n = link_valid;
        link_addr_n  = link_addr;
        op_ll_n      = op_ll;
        op_sc_n      = op_sc;
`endif
        case (state)
            IDLE: begin
                if (req && aligned) begin
`ifdef LLSC_EN
                    // a failing SC never touches memory and reports 0
                    if (sc_in && !(link_valid && (link_addr == aluResult_in))) begin
                        state_n      = DONE;
                        done_n       = 1'b1;
                        dout_n       = '0;
                        link_valid_n = 1'b0;
                    end else
`endif
                    begin
                        state_n  = BUSY;
                        dwen_n   = memWrite_in;
                        dren_n   = ~memWrite_in;
                        daddr_n  = aluResult_in;
                        dstore_n = storeData_in;
`ifdef LLSC_EN
                        op_ll_n  = ll_in & ~memWrite_in;
                        op_sc_n  = sc_in;
`endif
                    end
                end
            end
            BUSY: begin
                if (dhit) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    dren_n  = 1'b0;
                    dwen_n  = 1'b0;
                    if (dREN) begin
                        dout_n = dmemload;
                    end
`ifdef LLSC_EN
                    if (op_sc) begin
                        dout_n       = WORD_W'(1);
                        link_valid_n = 1'b0;
                    end else if (op_ll) begin
                        link_valid_n = 1'b1;
                        link_addr_n  = daddr;
                    end else if (dWEN && (daddr == link_addr)) begin
                        link_valid_n = 1'b0;
                    end
`endif
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table with scoreboard
// queue, plus hand-written reset sequences. Build with +define+LLSC_EN
// to also exercise the LL/SC reservation.
module tb_mem_access_ctrl;

    logic        CLK;
    logic        nRST;
    logic        memRead_in;
    logic        memWrite_in;
    logic [31:0] aluResult_in;
    logic [31:0] storeData_in;
`ifdef LLSC_EN
    logic        ll_in;
    logic        sc_in;
`endif
    logic        dhit;
    logic [31:0] dmemload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        mem_stall;
    logic        mem_done;
    logic [31:0] dmemload_out;
    logic        misalign;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic        ll;
        logic        sc;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hd;       // BUSY cycles before dhit (0 = first BUSY cycle)
        logic [31:0] rdata;
        logic [31:0] exp_out;
        logic        exp_mis;
        logic        exp_mem;  // access goes through BUSY
    } vec_t;

    vec_t vecs[7];
    vec_t lvecs[9];
    vec_t post_rst;

    mem_access_ctrl dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .memRead_in   (memRead_in),
        .memWrite_in  (memWrite_in),
        .aluResult_in (aluResult_in),
        .storeData_in (storeData_in),
`ifdef LLSC_EN
        .ll_in        (ll_in),
        .sc_in        (sc_in),
`endif
        .dhit         (dhit),
        .dmemload     (dmemload),
        .dREN         (dREN),
        .dWEN         (dWEN),
        .daddr        (daddr),
        .dstore       (dstore),
        .mem_stall    (mem_stall),
        .mem_done     (mem_done),
        .dmemload_out (dmemload_out),
        .misalign     (misalign)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        memRead_in   = 1'b0;
        memWrite_in  = 1'b0;
        aluResult_in = 32'h0;
        storeData_in = 32'h0;
`ifdef LLSC_EN
        ll_in        = 1'b0;
        sc_in        = 1'b0;
`endif
    endtask

    // called just after a falling edge; returns just after a falling edge
    task automatic run_access(input vec_t v);
        bit got;
        int busy;
        int lat;
        logic [31:0] exp;
        memRead_in   = v.rd;
        memWrite_in  = v.wr;
        aluResult_in = v.addr;
        storeData_in = v.wdata;
`ifdef LLSC_EN
        ll_in        = v.ll;
        sc_in        = v.sc;
`endif
        #1;
        if (v.exp_mis) begin
            chk("mis_flag", misalign, 1);
            chk("mis_stall", mem_stall, 0);
            repeat (3) begin
                @(negedge CLK); #1;
                chk("mis_dren", dREN, 0);
                chk("mis_dwen", dWEN, 0);
                chk("mis_done", mem_done, 0);
                chk("mis_hold", misalign, 1);
            end
            idle_inputs();
            #1;
            chk("mis_clear", misalign, 0);
        end else begin
            chk("req_stall", mem_stall, 1);
            chk("req_misalign", misalign, 0);
            sb_q.push_back(v.exp_out);
            got  = 0;
            busy = 0;
            lat  = -1;
            for (int c = 0; c < 64 && !got; c++) begin
                @(negedge CLK); #1;
                dhit     = 1'b0;
                dmemload = $urandom;
                if (mem_done) begin
                    got = 1;
                    lat = c;
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty: mem_done with no expected result");
                    end else begin
                        exp = sb_q.pop_front();
                        chk("done_data", dmemload_out, exp);
                    end
                    chk("done_dren", dREN, 0);
                    chk("done_dwen", dWEN, 0);
                    chk("done_stall", mem_stall, 0);
                end else if (!v.exp_mem) begin
                    chk("skip_dwen", dWEN, 0);
                end else begin
                    chk("busy_dren", dREN, !v.wr);
                    chk("busy_dwen", dWEN, v.wr);
                    chk("busy_daddr", daddr, v.addr);
                    if (v.wr) chk("busy_dstore", dstore, v.wdata);
                    chk("busy_stall", mem_stall, 1);
                    if (busy == v.hd) begin
                        dhit     = 1'b1;
                        dmemload = v.rdata;
                    end
                    busy++;
                end
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL timeout: got no mem_done expected mem_done within 64 cycles");
            end else begin
                chk("latency", 32'(lat), v.exp_mem ? 32'(v.hd + 1) : 32'd0);
            end
            // dhit outside BUSY must be ignored
            idle_inputs();
            dhit     = 1'b1;
            dmemload = 32'hBAD0BAD0;
            @(negedge CLK); #1;
            dhit = 1'b0;
            chk("pulse_end", mem_done, 0);
            chk("out_hold", dmemload_out, v.exp_out);
            chk("idle_stall", mem_stall, 0);
            chk("idle_dren", dREN, 0);
        end
    endtask

    initial begin
        //            rd   wr   ll   sc   addr          wdata         hd rdata         exp_out       mis  mem
        vecs[0] = '{1'b1,1'b0,1'b0,1'b0,32'h0000_0100,32'h0,        2, 32'hDEADBEEF,32'hDEADBEEF,1'b0,1'b1};
        vecs[1] = '{1'b0,1'b1,1'b0,1'b0,32'h0000_2000,32'h12345678, 5, 32'h0,       32'hDEADBEEF,1'b0,1'b1};
        vecs[2] = '{1'b1,1'b0,1'b0,1'b0,32'h0000_0104,32'h0,        0, 32'hCAFEF00D,32'hCAFEF00D,1'b0,1'b1};
        vecs[3] = '{1'b1,1'b0,1'b0,1'b0,32'h0000_0102,32'h0,        0, 32'h0,       32'hCAFEF00D,1'b1,1'b0};
        vecs[4] = '{1'b0,1'b1,1'b0,1'b0,32'h0000_2001,32'h55,       0, 32'h0,       32'hCAFEF00D,1'b1,1'b0};
        vecs[5] = '{1'b1,1'b1,1'b0,1'b0,32'h0000_3000,32'hA5A5A5A5, 2, 32'h0,       32'hCAFEF00D,1'b0,1'b1};
        vecs[6] = '{1'b1,1'b0,1'b0,1'b0,32'hFFFF_FFFC,32'h0,        3, 32'h00000000,32'h00000000,1'b0,1'b1};
        post_rst = '{1'b1,1'b0,1'b0,1'b0,32'h0000_0300,32'h0,       4, 32'h5A5A5A5A,32'h5A5A5A5A,1'b0,1'b1};
        lvecs[0] = '{1'b1,1'b0,1'b1,1'b0,32'h0000_0040,32'h0,       1, 32'h00000777,32'h00000777,1'b0,1'b1};
        lvecs[1] = '{1'b0,1'b1,1'b0,1'b1,32'h0000_0040,32'h0000AAAA,0, 32'h0,       32'h00000001,1'b0,1'b1};
        lvecs[2] = '{1'b0,1'b1,1'b0,1'b1,32'h0000_0040,32'h0000BBBB,0, 32'h0,       32'h00000000,1'b0,1'b0};
        lvecs[3] = '{1'b1,1'b0,1'b1,1'b0,32'h0000_0040,32'h0,       0, 32'h00000888,32'h00000888,1'b0,1'b1};
        lvecs[4] = '{1'b0,1'b1,1'b0,1'b0,32'h0000_0040,32'h00000005,1, 32'h0,       32'h00000888,1'b0,1'b1};
        lvecs[5] = '{1'b0,1'b1,1'b0,1'b1,32'h0000_0040,32'h0000CCCC,0, 32'h0,       32'h00000000,1'b0,1'b0};
        lvecs[6] = '{1'b1,1'b0,1'b1,1'b0,32'h0000_0040,32'h0,       0, 32'h00000999,32'h00000999,1'b0,1'b1};
        lvecs[7] = '{1'b0,1'b1,1'b0,1'b1,32'h0000_0044,32'h0000DDDD,0, 32'h0,       32'h00000000,1'b0,1'b0};
        lvecs[8] = '{1'b1,1'b0,1'b0,1'b0,32'h0000_0048,32'h0,       0, 32'h00000123,32'h00000123,1'b0,1'b1};

        // reset held with a load pending
        nRST = 1'b0;
        idle_inputs();
        memRead_in   = 1'b1;
        aluResult_in = 32'h0000_0100;
        dhit         = 1'b0;
        dmemload     = 32'h0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_dren", dREN, 0);
        chk("rst_dwen", dWEN, 0);
        chk("rst_daddr", daddr, 0);
        chk("rst_dstore", dstore, 0);
        chk("rst_dout", dmemload_out, 0);
        chk("rst_done", mem_done, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_misalign", misalign, 0);
        nRST = 1'b1;
        #1;
        chk("rel_stall_c0", mem_stall, 1);
        @(negedge CLK); #1;
        chk("rel_dren_c1", dREN, 1);
        chk("rel_daddr_c1", daddr, 32'h0000_0100);
        dhit     = 1'b1;
        dmemload = 32'h11111111;
        @(negedge CLK); #1;
        dhit = 1'b0;
        chk("rel_done_c2", mem_done, 1);
        chk("rel_dout_c2", dmemload_out, 32'h11111111);
        idle_inputs();
        @(negedge CLK); #1;
        chk("rel_pulse_end", mem_done, 0);

        for (int i = 0; i < 7; i++) run_access(vecs[i]);

        // reset pulse mid-BUSY drops the request with no completion
        memRead_in   = 1'b1;
        aluResult_in = 32'h0000_0200;
        #1;
        chk("mb_stall", mem_stall, 1);
        @(negedge CLK); #1;
        chk("mb_dren", dREN, 1);
        nRST = 1'b0;
        #1;
        chk("mb_rst_dren", dREN, 0);
        chk("mb_rst_stall", mem_stall, 0);
        chk("mb_rst_daddr", daddr, 0);
        idle_inputs();
        @(negedge CLK); #1;
        nRST = 1'b1;
        repeat (3) begin
            @(negedge CLK); #1;
            chk("mb_no_done", mem_done, 0);
            chk("mb_idle_dren", dREN, 0);
        end
        chk("mb_dout", dmemload_out, 0);
        run_access(post_rst);

`ifdef LLSC_EN
        for (int i = 0; i < 9; i++) run_access(lvecs[i]);
`endif

        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller for the pipelined MIPS core. It sits between the EX/MEM latch and the MEM/WB latch: it converts the load/store decoded upstream into a held dREN/dWEN request to the data cache, stalls the pipeline until dhit, and presents captured load data to the MEM/WB latch. It also tracks the load-linked reservation for LL/SC when that feature is compiled in.

## Interface
- No parameters. Word size is fixed at 32 bits (word_t).
- CLK  in  1  core clock, rising edge
- nRST  in  1  asynchronous active-low reset
- memRead_in  in  1  load in MEM stage (from EX/MEM)
- memWrite_in  in  1  store in MEM stage (from EX/MEM)
- aluResult_in  in  32  effective byte address
- storeData_in  in  32  store data (rt)
- ll_in  in  1  instruction is LL (LLSC_EN only)
- sc_in  in  1  instruction is SC (LLSC_EN only)
- dhit  in  1  cache completed current request
- dmemload  in  32  cache read data
- dREN  out  1  cache read request
- dWEN  out  1  cache write request
- daddr  out  32  cache address
- dstore  out  32  cache write data
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM latches
- mem_done  out  1  one-cycle pulse: access complete, dmemload_out valid
- dmemload_out  out  32  load data (or SC result) to MEM/WB dmemload_in
- misalign  out  1  request address not word aligned

## Operation
- States: IDLE, BUSY, DONE.
- req = memRead_in | memWrite_in. If both are set, it is a store (write wins).
- IDLE:
  - If req and aluResult_in[1:0]==0: latch address, data and type, then go to BUSY.
  - If req and aluResult_in[1:0]!=0: misalign=1 (combinational), no access, stay IDLE, no stall.
- BUSY:
  - dREN or dWEN is held at 1 with stable daddr/dstore.
  - On dhit: capture dmemload into dmemload_out (loads only; stores leave it unchanged), deassert dREN/dWEN, go to DONE.
  - dhit is ignored in IDLE and DONE.
- DONE:
  - mem_done=1 and mem_stall=0, so upstream latches advance on this edge.
  - Request inputs are ignored (they still show the completed instruction).
  - Next state is always IDLE.
- mem_stall = (IDLE & req & aligned) | BUSY. Combinational, forced 0 while nRST=0.
- Reset values: state IDLE, dREN=0, dWEN=0, daddr=0, dstore=0, dmemload_out=0, mem_done=0, link_valid=0, link_addr=0.
- Reset asserted mid-BUSY drops the request asynchronously. No completion is reported.

## Timing
- Request seen in cycle N (IDLE):
  - mem_stall=1 in N.
  - dREN/dWEN=1 from N+1.
  - dhit in cycle M ≥ N+1 gives DONE in M+1.
- Minimum occupancy is 3 cycles (IDLE-detect, BUSY, DONE).
- The next instruction is evaluated in IDLE at M+2.
- dREN/dWEN/daddr/dstore/dmemload_out/mem_done are registered outputs. mem_stall and misalign are combinational.

## Configuration
- LLSC_EN defined: ll_in/sc_in ports exist, plus link_valid/link_addr registers.
  - LL (a load) on completion sets link_valid=1 and link_addr=address.
  - SC with link_valid and address==link_addr performs the store. It completes through BUSY/DONE with dmemload_out=1.
  - SC otherwise skips memory: IDLE→DONE directly, no dWEN, dmemload_out=0, one stall cycle.
  - Any SC completion clears link_valid.
  - A regular store completing to link_addr clears link_valid.
- LLSC_EN undefined: ll_in/sc_in ports and link registers are absent. All loads/stores are plain.

## Test plan
- Reset with memRead_in=1 held → all outputs 0, state IDLE. Release at cycle 0 → mem_stall=1 at 0, dREN=1/daddr=0x100 at cycle 1.
- Load 0x100, dhit at cycle 3 with dmemload=0xDEADBEEF → mem_done=1 and dmemload_out=0xDEADBEEF at cycle 4. mem_stall=0 at 4. dREN=0 at 4.
- Store 0x2000 data 0x12345678, dhit after 5 BUSY cycles → dWEN/dstore stable throughout. Single mem_done pulse. dmemload_out unchanged.
- Load address 0x102 → misalign=1, dREN never asserted, mem_stall=0, mem_done=0.
- nRST pulsed low while BUSY → dREN drops immediately. No mem_done follows; next request restarts normally.
- (LLSC_EN) LL 0x40, SC 0x40 → dWEN issued, dmemload_out=1. Repeat SC 0x40 → no dWEN, dmemload_out=0 one cycle after request. LL 0x40, SW 0x40, SC 0x40 → SC fails (0).
